// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage: iterative shift-add / restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a registered full multiplier.
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [4:0]        wd_i,
    input  logic              annul,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        wd_o,
    output logic              done,
    output logic              stallreq
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_cnt;
    logic [2:0]     r_op;
    logic [4:0]     r_wd;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_b;
    logic           r_neg;
    logic           r_negr;
    logic           r_raw;

    logic           w_is_mul;
    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_ma;
    logic [W-1:0]   w_mb;
    logic           w_div0;
    logic           w_ovf;
    logic           w_fast;
    logic           w_go;
    logic [W:0]     w_msum;
    logic [W:0]     w_dsh;
    logic [W:0]     w_ddiff;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_q;
    logic [W-1:0]   w_r;
    logic [W-1:0]   w_res;
    logic [W-1:0]   w_min;

    assign w_min    = {1'b1, {(W-1){1'b0}}};
    assign w_is_mul = ~op[2];
    assign w_sa     = op[2] ? ~op[0] : (op != 3'd3);
    assign w_sb     = op[2] ? ~op[0] : ~op[1];
    assign w_ma     = (w_sa & reg1[W-1]) ? -reg1 : reg1;
    assign w_mb     = (w_sb & reg2[W-1]) ? -reg2 : reg2;
    assign w_div0   = op[2] & (reg2 == '0);
    assign w_ovf    = op[2] & ~op[0] & (reg1 == w_min) & (&reg2);
`ifdef MULDIV_FAST_MUL_EN
    assign w_fast   = w_div0 | w_ovf | w_is_mul;
`else
    assign w_fast   = w_div0 | w_ovf;
`endif
    assign w_go     = (r_state == S_IDLE) & start & ~annul;

    // One multiply step: conditionally add multiplicand to the high half, shift right.
    assign w_msum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // One restoring-divide step: shift remainder:quotient left, trial-subtract.
    assign w_dsh   = r_acc[2*W-1:W-1];
    assign w_ddiff = w_dsh - {1'b0, r_b};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_next = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 5'd31) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (annul) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_wd    <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_negr  <= 1'b0;
            r_raw   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_cnt  <= '0;
                r_op   <= op;
                r_wd   <= wd_i;
                r_neg  <= (w_sa & reg1[W-1]) ^ (w_sb & reg2[W-1]);
                r_negr <= w_sa & reg1[W-1];
                r_raw  <= w_div0 | w_ovf;
                if (w_div0) begin
                    r_acc <= {reg1, {W{1'b1}}};
                    r_b   <= '0;
                end else if (w_ovf) begin
                    r_acc <= {{W{1'b0}}, w_min};
                    r_b   <= '0;
                end else if (w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                    r_acc <= {{W{1'b0}}, w_ma} * {{W{1'b0}}, w_mb};
`else
                    r_acc <= {{W{1'b0}}, w_mb};
`endif
                    r_b   <= w_ma;
                end else begin
                    r_acc <= {{W{1'b0}}, w_ma};
                    r_b   <= w_mb;
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 5'd1;
                if (!r_op[2]) begin
                    r_acc <= {w_msum, r_acc[W-1:1]};
                end else if (!w_ddiff[W]) begin
                    r_acc <= {w_ddiff[W-1:0], r_acc[W-2:0], 1'b1};
                end else begin
                    r_acc <= {r_acc[2*W-2:0], 1'b0};
                end
            end
        end
    end

    // Sign fix-up on magnitudes; fast-path div results are already final.
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_q    = (r_neg & ~r_raw) ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_r    = (r_negr & ~r_raw) ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_res = '0;
        unique case (r_op)
            3'd0:    w_res = w_prod[W-1:0];
            3'd1,
            3'd2,
            3'd3:    w_res = w_prod[2*W-1:W];
            3'd4,
            3'd5:    w_res = w_q;
            default: w_res = w_r;
        endcase
    end

    assign done     = (r_state == S_DONE) & ~annul;
    assign result   = done ? w_res : '0;
    assign wd_o     = done ? r_wd : '0;
    assign stallreq = start & ~annul & ~rst & (r_state != S_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, latency and flush/reset checks.
module tb_ex_muldiv;
    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd_i;
    logic        annul;
    logic [31:0] result;
    logic [4:0]  wd_o;
    logic        done;
    logic        stallreq;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  wd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    ex_muldiv #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .reg1(reg1), .reg2(reg2), .wd_i(wd_i), .annul(annul),
        .result(result), .wd_o(wd_o), .done(done), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_result"}, 64'(result), 64'(e.res));
                    chk({e.name, "_wd"}, 64'(wd_o), 64'(e.wd));
                    chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("idle_result_zero", 64'(result), 64'd0);
                chk("idle_wd_zero", 64'(wd_o), 64'd0);
            end
        end
    end

    // Called just after a rising edge; holds start while the unit stalls.
    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] w,
                         input logic [31:0] er, input int lat, input bit scramble);
        logic stalled;
        int   n;
        start = 1'b1; op = o; reg1 = a; reg2 = b; wd_i = w;
        exp_q.push_back('{nm, er, w, cyc + lat});
        n = 0;
        do begin
            @(negedge clk);
            stalled = stallreq;
            @(posedge clk);
            #1;
            if (scramble) begin
                op = ~o; reg1 = ~a; reg2 = $urandom; wd_i = ~w;
            end
            n++;
        end while (stalled && n < 40);
        if (n >= 40) chk({nm, "_timeout"}, 64'(n), 64'(lat));
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 3'd4; reg1 = 32'd5; reg2 = 32'd1;
        wd_i = 5'd3; annul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_wd", 64'(wd_o), 64'd0);
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        issue("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 33, 1'b0);
        issue("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 33, 1'b1);
        issue("divu_by0",   3'd5, 32'd100, 32'd0, 5'd3, 32'hFFFFFFFF, 1, 1'b0);
        issue("remu_by0",   3'd7, 32'd100, 32'd0, 5'd4, 32'd100, 1, 1'b1);
        issue("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h80000000, 1, 1'b0);
        issue("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'd0, 1, 1'b0);
        issue("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 5'd7, 32'h40000000, ML, 1'b0);
        issue("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, ML, 1'b1);
        issue("mul_max",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'd1, ML, 1'b0);
        issue("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'd2, 5'd10, 32'hFFFFFFFF, ML, 1'b0);
        issue("mulh_m3_5",  3'd1, 32'hFFFFFFFD, 32'd5, 5'd11, 32'hFFFFFFFF, ML, 1'b0);
        issue("div_7_m2",   3'd4, 32'd7, 32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33, 1'b0);
        issue("rem_7_m2",   3'd6, 32'd7, 32'hFFFFFFFE, 5'd13, 32'd1, 33, 1'b0);
        issue("remu_10_3",  3'd7, 32'd10, 32'd3, 5'd14, 32'd1, 33, 1'b0);
        issue("div_m8_0",   3'd4, 32'hFFFFFFF8, 32'd0, 5'd15, 32'hFFFFFFFF, 1, 1'b0);
        issue("rem_m8_0",   3'd6, 32'hFFFFFFF8, 32'd0, 5'd16, 32'hFFFFFFF8, 1, 1'b0);

        // Flush a DIVU at count 10, then a MUL must run normally.
        start = 1'b1; op = 3'd5; reg1 = 32'd1000; reg2 = 32'd7; wd_i = 5'd20;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        chk("annul_stallreq", 64'(stallreq), 64'd0);
        chk("annul_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_annul_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        issue("mul_3_5",    3'd0, 32'd3, 32'd5, 5'd21, 32'd15, ML, 1'b0);

        // Reset mid-op at count 20, then a fresh DIVU.
        start = 1'b1; op = 3'd5; reg1 = 32'd1000; reg2 = 32'd7; wd_i = 5'd22;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_wd", 64'(wd_o), 64'd0);
        chk("midrst_stallreq", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        issue("divu_9_3",   3'd5, 32'd9, 32'd3, 5'd23, 32'd3, 33, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pending_expect", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
